// File: rtl/tff_count_seq.sv
// Load/count/pause/done sequencer that drives the toggle enables of a W-bit toggle-flop bank.
// All count changes pass through t_vec; the bank itself only ever does q <= q ^ t.

module tff_count_seq_bank #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] t,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// Handshake: start is consumed only in IDLE; done stays high in DONE until
// done_ack is seen at an edge, which returns to IDLE. abort wins over everything.
module tff_count_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic [W-1:0] limit,
  input  logic         pause,
  input  logic         abort,
  input  logic         done_ack,
  output logic [W-1:0] t_vec,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         dir_q, dir_d;
  logic [W-1:0] lim_q, lim_d;
  logic [W-1:0] t_d;
  logic [W-1:0] t_run;
  logic [W-1:0] init;
  logic [W-1:0] term;
  logic         carry;

  // Up: bit i toggles when all lower bits are 1; down: when all lower bits are 0.
  always_comb begin
    t_run = '0;
    carry = 1'b1;
    for (int i = 0; i < W; i++) begin
      t_run[i] = carry;
      carry    = carry & (dir_q ? count[i] : ~count[i]);
    end
  end

  always_comb begin
    init = dir_q ? '0 : lim_q;
    term = dir_q ? lim_q : '0;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lim_d   = lim_q;
    t_d     = '0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_d   = dir;
            lim_d   = limit;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          t_d     = count ^ init;
          state_d = (init == term) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (!pause) begin
            t_d = t_run;
            if ((count ^ t_run) == term) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (done_ack) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      lim_q   <= lim_d;
    end
  end

  tff_count_seq_bank #(.W(W)) u_bank (
    .clk   (clk),
    .rst_n (reset),
    .t     (t_vec),
    .q     (count)
  );

  assign t_vec     = reset ? t_d : '0;
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tff_count_seq.sv
// Bench for tff_count_seq: directed vector table, multi-cycle corner sequences,
// and random traffic checked against an arithmetic model of the counter run.

module tb_tff_count_seq;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, dir, pause, abort, done_ack;
  logic [3:0] limit;
  logic [3:0] t_vec, count;
  logic       busy, done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  int m_phase = P_IDLE;
  int m_cnt   = 0;
  bit m_up    = 1'b0;
  int m_lim   = 0;

  typedef struct {
    logic       s, d;
    logic [3:0] l;
    logic       p, a, k;
    logic [3:0] e_t, e_cnt;
    logic       e_busy, e_done;
  } vec_t;

  vec_t tbl[14];

  tff_count_seq #(.W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .limit     (limit),
    .pause     (pause),
    .abort     (abort),
    .done_ack  (done_ack),
    .t_vec     (t_vec),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic d, input logic [3:0] l,
                              input logic p, input logic a, input logic k,
                              input logic [3:0] et, input logic [3:0] ec,
                              input logic eb, input logic ed);
    vec_t v;
    v.s = s; v.d = d; v.l = l; v.p = p; v.a = a; v.k = k;
    v.e_t = et; v.e_cnt = ec; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  // Called at a falling edge; applies one cycle of inputs and checks against the model.
  task automatic step(input logic s, input logic d, input logic [3:0] l,
                      input logic p, input logic a, input logic k,
                      output logic [3:0] t_seen);
    int nc, np, nlim;
    bit nup;
    start = s; dir = d; limit = l; pause = p; abort = a; done_ack = k;
    #1;
    nc = m_cnt; np = m_phase; nup = m_up; nlim = m_lim;
    if (a) begin
      np = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE: if (s) begin nup = d; nlim = int'(l); np = P_LOAD; end
        P_LOAD: begin
          nc = m_up ? 0 : m_lim;
          np = (nc == (m_up ? m_lim : 0)) ? P_DONE : P_RUN;
        end
        P_RUN: if (!p) begin
          nc = m_up ? m_cnt + 1 : m_cnt - 1;
          if (nc == (m_up ? m_lim : 0)) np = P_DONE;
        end
        default: if (k) np = P_IDLE;
      endcase
    end
    t_seen = t_vec;
    chk("t_vec", t_vec, 4'(m_cnt ^ nc));
    @(posedge clk);
    m_cnt = nc; m_phase = np; m_up = nup; m_lim = nlim;
    #1;
    chk("count", count, 4'(m_cnt));
    chk("busy", {3'b0, busy}, 4'(m_phase == P_LOAD || m_phase == P_RUN));
    chk("done", {3'b0, done}, 4'(m_phase == P_DONE));
    @(negedge clk);
  endtask

  task automatic run_until_done(input int max, output int edges);
    logic [3:0] tv;
    edges = 0;
    while (!done && edges < max) begin
      step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, tv);
      edges++;
    end
    chk("done_reached", {3'b0, done}, 4'd1);
  endtask

  initial begin
    logic [3:0] tv;
    int edges, total;

    tbl[0]  = mk(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h1, 4'd1, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h3, 4'd2, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h1, 4'd3, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h7, 4'd4, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h1, 4'd5, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd5, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'h0, 4'd5, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'd5, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 4'h0, 4'd5, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'hC, 4'd9, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'h1, 4'd8, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'hF, 4'd7, 1'b1, 1'b0);

    reset = 1'b0;
    start = 1'b0; dir = 1'b0; limit = 4'd0; pause = 1'b0; abort = 1'b0; done_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_done", {3'b0, done}, 4'd0);
    chk("rst_t_vec", t_vec, 4'd0);
    reset = 1'b1;
    @(negedge clk);

    // Up run to 5, done hold, ack with start ignored, then the down run to 9 begins.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].l, tbl[i].p, tbl[i].a, tbl[i].k, tv);
      chk($sformatf("tbl%0d_t", i), tv, tbl[i].e_t);
      chk($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_busy", i), {3'b0, busy}, {3'b0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_done", i), {3'b0, done}, {3'b0, tbl[i].e_done});
    end

    // Down run from 9 finishes at E10; rows 10..13 covered E0..E3.
    run_until_done(20, edges);
    chk_int("down_done_latency", edges + 4, 11);
    repeat (3) step(1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, tv);
    chk("done_hold_cnt", count, 4'd0);
    chk("done_hold_done", {3'b0, done}, 4'd1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, tv);

    // Up to 15 with a 3-cycle pause at 7.
    total = 0;
    step(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, tv); total++;
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv); total++;
    repeat (7) begin step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv); total++; end
    chk("pre_pause_cnt", count, 4'd7);
    repeat (3) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, tv); total++;
      chk("pause_t", tv, 4'd0);
      chk("pause_cnt", count, 4'd7);
    end
    run_until_done(20, edges);
    chk_int("pause_done_latency", total + edges, 17 + 3);

    // limit=0 both directions: one busy cycle, then DONE.
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, tv);
    step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    chk("lim0_busy", {3'b0, busy}, 4'd1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    chk("lim0_load_t", tv, 4'hF);
    chk("lim0_done", {3'b0, done}, 4'd1);
    chk("lim0_busy_drop", {3'b0, busy}, 4'd0);
    step(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, tv);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    chk("ack_start_ignored", {3'b0, busy}, 4'd0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    chk("lim0_down_done", {3'b0, done}, 4'd1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, tv);

    // Abort at 6 during an up run to 12.
    step(1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, tv);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    repeat (6) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, tv);
    chk("abort_t", tv, 4'd0);
    chk("abort_cnt", count, 4'd6);
    chk("abort_busy", {3'b0, busy}, 4'd0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    chk("abort_hold_cnt", count, 4'd6);

    // Async reset mid-run, sampled before the next rising edge.
    step(1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, tv);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    repeat (3) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);
    chk("pre_reset_cnt", count, 4'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_cnt", count, 4'd0);
    chk("async_rst_busy", {3'b0, busy}, 4'd0);
    chk("async_rst_done", {3'b0, done}, 4'd0);
    chk("async_rst_t", t_vec, 4'd0);
    m_phase = P_IDLE; m_cnt = 0; m_up = 1'b0; m_lim = 0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tv);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) == 0, tv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
